mdu: RTL
========

MDU -- requirements
Module: mdu

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The module SHALL have the port nreset, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The module SHALL have the port StartE, input, 1 bit: a one-cycle request to start an operation.
REQ-004 The module SHALL have the port MDFuncE, input, 2 bits: 00 MUL (low 32 bits of product), 01 MULHU (high 32 bits, unsigned), 10 DIVU, 11 REMU.
REQ-005 The module SHALL have the ports OpA and OpB, input, 32 bits each: unsigned operands, sampled only when a start is accepted.
REQ-006 The module SHALL have the port FlushE, input, 1 bit: aborts any operation in progress.
REQ-007 The module SHALL have the port Busy, output, 1 bit: high while an operation is in progress (state MUL or DIV).
REQ-008 The module SHALL have the port Done, output, 1 bit: a one-cycle pulse when result becomes valid.
REQ-009 The module SHALL have the port result, output, 32 bits: the operation result.
REQ-010 The module SHALL have the ports Z and N, output, 1 bit each: Z = (result == 0) and N = result[31], derived combinationally from result.

Function
REQ-011 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-012 In IDLE or DONE, StartE=1 SHALL be accepted:
- OpA, OpB and MDFuncE latch.
- The 6-bit iteration counter loads 0.
- The FSM goes to MUL (MDFuncE[1]=0) or DIV (MDFuncE[1]=1).
REQ-013 StartE in MUL or DIV SHALL be ignored; the operands and the operation in progress SHALL be unaffected.
REQ-014 MUL SHALL run a radix-2 shift-add over a 64-bit product register, one multiplier bit per cycle, for exactly 32 cycles.
REQ-015 DIV SHALL run a restoring division over a 32-bit remainder and a 32-bit quotient, one quotient bit per cycle, for exactly 32 cycles.
REQ-016 After the 32nd iteration cycle (counter = 31), the FSM SHALL enter DONE.
- Done=1 for exactly that one cycle.
- Latency from the accept edge to the Done cycle is 33 cycles.
REQ-017 result SHALL be selected by the latched function: MUL = product[31:0], MULHU = product[63:32], DIVU = quotient, REMU = remainder.
REQ-018 result SHALL hold its value through DONE and in IDLE until the next accepted start.
REQ-019 From DONE with no start, the FSM SHALL go to IDLE. A start in DONE SHALL be accepted as in REQ-012 (back-to-back operation).
REQ-020 Division by zero (latched OpB = 0) SHALL skip iteration and go directly to DONE on the next edge:
- DIVU result = 32'hFFFFFFFF.
- REMU result = latched OpA.
REQ-021 Multiplication with either operand 0 SHALL still take 32 cycles; there is no early-out.
REQ-022 FlushE=1 SHALL take effect at the next clock edge, with priority over StartE:
- The FSM goes to IDLE.
- Busy=0 and no Done is produced.
- result is cleared to 0.
REQ-023 All arithmetic SHALL be unsigned, modulo 2^32 per result word. Intermediate subtraction SHALL use a 33-bit width so the borrow is detected.
REQ-024 Busy SHALL be a registered-state decode, with no combinational path from StartE.

Reset
REQ-025 nreset=0 SHALL asynchronously force:
- state IDLE
- counter 0
- all datapath registers 0
- result 0 (hence Z=1, N=0)
- Busy=0, Done=0
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no Done. After reset deassertion the first accepted start SHALL behave normally.

Structure
REQ-027 A shared package SHALL hold:
- the MDFuncE encoding enum (MUL, MULHU, DIVU, REMU)
- the FSM state enum
- the constant for the iteration count (32)
REQ-028 The divider step (33-bit compare/subtract, quotient-bit generation) SHALL be a sub-module named mdu_div_step. The FSM, counter and multiplier SHALL remain in mdu.

Verification
REQ-029 MUL, OpA=7, OpB=6 -> Done exactly 33 cycles after the accept edge; result=42, Z=0, N=0.
REQ-030 MULHU, OpA=OpB=32'hFFFFFFFF -> result=32'hFFFFFFFE. A follow-up MUL with the same operands -> result=1.
REQ-031 DIVU, OpA=100, OpB=7 -> result=14. REMU with the same operands -> result=2. DIVU, OpA=5, OpB=9 -> result=0, Z=1.
REQ-032 DIVU and REMU with OpA=123, OpB=0 -> Done on the 2nd edge after accept; result=32'hFFFFFFFF (N=1) and 123 respectively.
REQ-033 Abort and ignore cases:
- FlushE on cycle 10 of a DIVU -> Busy=0 next cycle, no Done, result=0.
- nreset pulse mid-MUL -> same outcome.
- StartE with new operands while Busy -> ignored; the original result is delivered.
REQ-034 Back-to-back starts:
- StartE on the Done cycle -> new operation accepted; next Done 33 cycles later with no idle gap.
- Random 10k unsigned operand pairs -> results match a reference model.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit: function
// encoding, FSM states and the iteration count.
package mdu_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    FN_MUL   = 2'b00,
    FN_MULHU = 2'b01,
    FN_DIVU  = 2'b10,
    FN_REMU  = 2'b11
  } mdu_func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep or restore the partial remainder.
module mdu_div_step
  import mdu_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] trial;
  logic [DATA_W:0] diff;

  assign trial = {rem_in, dividend_bit};
  assign diff  = trial - {1'b0, divisor};

  // rem_in < divisor always holds, so trial < 2*divisor and bit 32 of the
  // difference is set exactly when the subtraction borrows.
  assign q_bit   = ~diff[DATA_W];
  assign rem_out = q_bit ? diff[DATA_W-1:0] : trial[DATA_W-1:0];

endmodule

// File: rtl/mdu.sv
// Iterative 32-bit unsigned multiply/divide unit: radix-2 shift-add multiply
// and restoring divide, one bit per cycle, with flush and back-to-back starts.
module mdu
  import mdu_pkg::*;
(
  input  logic              clk,
  input  logic              nreset,
  input  logic              StartE,
  input  logic [1:0]        MDFuncE,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  input  logic              FlushE,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] result,
  output logic              Z,
  output logic              N
);

  mdu_state_e          state_reg;
  mdu_func_e           func_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [DATA_W-1:0]   op_a_reg;
  logic [DATA_W-1:0]   op_b_reg;
  logic [DATA_W-1:0]   rem_reg;
  logic [DATA_W-1:0]   quo_reg;
  logic [DATA_W-1:0]   result_reg;
  logic [2*DATA_W-1:0] prod_reg;

  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_next;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic                q_bit;
  logic                last_iter;

  // Multiplier lives in the low half of prod_reg and is consumed LSB first;
  // the carry of the upper-half add shifts back in at the top.
  assign mul_sum   = {1'b0, prod_reg[2*DATA_W-1:DATA_W]}
                   + (prod_reg[0] ? {1'b0, op_a_reg} : {(DATA_W+1){1'b0}});
  assign prod_next = {mul_sum, prod_reg[DATA_W-1:1]};

  // quo_reg starts as the dividend and fills with quotient bits from the right.
  mdu_div_step u_div_step (
    .rem_in       (rem_reg),
    .dividend_bit (quo_reg[DATA_W-1]),
    .divisor      (op_b_reg),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  assign quo_next  = {quo_reg[DATA_W-2:0], q_bit};
  assign last_iter = (count_reg == CNT_W'(ITER_COUNT - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg  <= ST_IDLE;
      func_reg   <= FN_MUL;
      count_reg  <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      prod_reg   <= '0;
      result_reg <= '0;
    end else if (FlushE) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (StartE) begin
            op_a_reg  <= OpA;
            op_b_reg  <= OpB;
            func_reg  <= mdu_func_e'(MDFuncE);
            count_reg <= '0;
            prod_reg  <= {{DATA_W{1'b0}}, OpB};
            rem_reg   <= '0;
            quo_reg   <= OpA;
            state_reg <= MDFuncE[1] ? ST_DIV : ST_MUL;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_MUL: begin
          prod_reg  <= prod_next;
          count_reg <= count_reg + CNT_W'(1);
          if (last_iter) begin
            state_reg  <= ST_DONE;
            result_reg <= (func_reg == FN_MULHU) ? prod_next[2*DATA_W-1:DATA_W]
                                                 : prod_next[DATA_W-1:0];
          end
        end
        ST_DIV: begin
          if (op_b_reg == '0) begin
            rem_reg    <= op_a_reg;
            quo_reg    <= '1;
            result_reg <= (func_reg == FN_REMU) ? op_a_reg : '1;
            state_reg  <= ST_DONE;
          end else begin
            rem_reg   <= rem_next;
            quo_reg   <= quo_next;
            count_reg <= count_reg + CNT_W'(1);
            if (last_iter) begin
              state_reg  <= ST_DONE;
              result_reg <= (func_reg == FN_REMU) ? rem_next : quo_next;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign Busy   = (state_reg == ST_MUL) || (state_reg == ST_DIV);
  assign Done   = (state_reg == ST_DONE);
  assign result = result_reg;
  assign Z      = (result_reg == '0);
  assign N      = result_reg[DATA_W-1];

endmodule
